// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX pipeline register that sits directly in front of the ALU.
//   It does four things:
//   - Captures the decoded operands and control from ID.
//   - Resolves EX/MEM and MEM/WB forwarding for rs1 and rs2.
//   - Selects the immediate for SrcB.
//   - Detects load-use hazards and inserts a bubble for them.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   id_*              decoded instruction from ID (valid, data, indices, control)
//   stall             hold EX contents unchanged
//   flush             kill EX contents (branch/jump redirect)
//   mem_*, wb_*       forwarding sources from EX/MEM and MEM/WB
//   ex_valid          EX slot holds a real instruction
//   SrcA, SrcB        ALU operands (forwarded; SrcB may be the immediate)
//   Operation         ALU operation code (0 in a bubble)
//   ex_store_data     forwarded rs2 value for stores
//   ex_rd             EX destination index
//   ex_reg_write/ex_mem_read/ex_mem_write  control, gated by ex_valid
//   load_use_hazard   combinational; IF/ID must hold while asserted
module ex_operand_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_alu_src,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [REG_ADDR_W-1:0]    mem_rd,
  input  logic                     mem_reg_write,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic [REG_ADDR_W-1:0]    wb_rd,
  input  logic                     wb_reg_write,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  output logic                     ex_valid,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     load_use_hazard
);

  logic                     valid_q,     valid_d;
  logic [DATA_WIDTH-1:0]    rs1_data_q,  rs1_data_d;
  logic [DATA_WIDTH-1:0]    rs2_data_q,  rs2_data_d;
  logic [DATA_WIDTH-1:0]    imm_q,       imm_d;
  logic [REG_ADDR_W-1:0]    rs1_q,       rs1_d;
  logic [REG_ADDR_W-1:0]    rs2_q,       rs2_d;
  logic [REG_ADDR_W-1:0]    rd_q,        rd_d;
  logic [OPCODE_LENGTH-1:0] alu_op_q,    alu_op_d;
  logic                     alu_src_q,   alu_src_d;
  logic                     reg_write_q, reg_write_d;
  logic                     mem_read_q,  mem_read_d;
  logic                     mem_write_q, mem_write_d;

  logic [DATA_WIDTH-1:0] fwd_rs1;
  logic [DATA_WIDTH-1:0] fwd_rs2;

  // EX/MEM wins over MEM/WB because it carries the younger result.
  // x0 is never forwarded since it always reads as zero.
  function automatic logic [DATA_WIDTH-1:0] forward(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [DATA_WIDTH-1:0] rf_data
  );
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs))
      return mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs))
      return wb_result;
    else
      return rf_data;
  endfunction

  assign fwd_rs1 = forward(rs1_q, rs1_data_q);
  assign fwd_rs2 = forward(rs2_q, rs2_data_q);

  assign ex_valid      = valid_q;
  assign SrcA          = fwd_rs1;
  assign SrcB          = alu_src_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign Operation     = alu_op_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q & valid_q;
  assign ex_mem_read   = mem_read_q  & valid_q;
  assign ex_mem_write  = mem_write_q & valid_q;

  // rs2 is checked even when the immediate feeds SrcB: a store still
  // needs rs2 as its data.
  assign load_use_hazard = ex_valid & ex_mem_read & id_valid & (ex_rd != '0) &
                           ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  always_comb begin
    valid_d     = valid_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_op_d    = alu_op_q;
    alu_src_d   = alu_src_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (flush || (!stall && load_use_hazard)) begin
      // Bubble: control cleared, data fields left as they were.
      valid_d     = 1'b0;
      alu_op_d    = '0;
      alu_src_d   = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!stall) begin
      valid_d     = id_valid;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      alu_op_d    = id_alu_op;
      alu_src_d   = id_alu_src;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_op_q    <= alu_op_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed testbench for ex_operand_stage.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic        stall, flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid;
  logic [31:0] SrcA, SrcB, ex_store_data;
  logic [3:0]  Operation;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;

  int total = 0;
  int bad   = 0;

  ex_operand_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0;
    id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
  endtask

  task automatic clear_fwd();
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    clear_id();
    clear_fwd();
    step();
    step();
    check("rst_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_op", {28'b0, Operation}, 32'd0);
    check("rst_srca", SrcA, 32'd0);
    check("rst_srcb", SrcB, 32'd0);
    check("rst_ctrl", {29'b0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    reset = 0;

    // Basic capture with immediate for SrcB
    id_valid = 1; id_rs1 = 1; id_rs1_data = 5; id_imm = 7; id_alu_src = 1;
    id_alu_op = 4'b0010; id_rd = 2; id_reg_write = 1;
    step();
    check("cap_srca", SrcA, 32'd5);
    check("cap_srcb", SrcB, 32'd7);
    check("cap_op", {28'b0, Operation}, 32'h2);
    check("cap_valid", {31'b0, ex_valid}, 32'd1);
    check("cap_rw", {31'b0, ex_reg_write}, 32'd1);

    // Asynchronous reset mid-cycle, checked before the next edge
    #2 reset = 1;
    #1;
    check("arst_valid", {31'b0, ex_valid}, 32'd0);
    check("arst_op", {28'b0, Operation}, 32'd0);
    check("arst_rw", {31'b0, ex_reg_write}, 32'd0);
    #1 reset = 0;

    // Forwarding priority
    clear_id();
    id_valid = 1; id_rs1 = 3; id_rs1_data = 1; id_rs2 = 4; id_rs2_data = 32'h44;
    id_alu_op = 4'b0110;
    step();
    mem_reg_write = 1; mem_rd = 3; mem_result = 32'hAA;
    wb_reg_write = 1;  wb_rd = 3;  wb_result = 32'hBB;
    #1;
    check("fwd_mem", SrcA, 32'hAA);
    check("fwd_rs2_nomatch", SrcB, 32'h44);
    mem_reg_write = 0;
    #1;
    check("fwd_wb", SrcA, 32'hBB);
    wb_reg_write = 0;
    #1;
    check("fwd_none", SrcA, 32'd1);

    // x0 never forwarded
    id_rs1 = 0; id_rs1_data = 32'h55;
    mem_reg_write = 1; mem_rd = 0; wb_reg_write = 1; wb_rd = 0;
    step();
    check("fwd_x0", SrcA, 32'h55);
    clear_fwd();

    // Load-use hazard on rs2 (immediate instruction still hazards)
    clear_id();
    id_valid = 1; id_rs1 = 1; id_rs1_data = 32'h100; id_imm = 4; id_alu_src = 1;
    id_rd = 5; id_mem_read = 1; id_reg_write = 1;
    step();
    check("ld_memread", {31'b0, ex_mem_read}, 32'd1);
    clear_id();
    id_valid = 1; id_rs1 = 6; id_rs2 = 5; id_rd = 8; id_alu_op = 4'b0011;
    id_reg_write = 1; id_alu_src = 1;
    #1;
    check("lu_hazard", {31'b0, load_use_hazard}, 32'd1);
    step();
    check("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
    check("lu_bubble_rw", {31'b0, ex_reg_write}, 32'd0);
    check("lu_cleared", {31'b0, load_use_hazard}, 32'd0);
    step();
    check("lu_resume_valid", {31'b0, ex_valid}, 32'd1);
    check("lu_resume_op", {28'b0, Operation}, 32'h3);
    check("lu_resume_rd", {27'b0, ex_rd}, 32'd8);

    // Stall holds, then flush beats stall
    id_alu_op = 4'b0101; id_rd = 9;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_op", {28'b0, Operation}, 32'h3);
      check("stall_rd", {27'b0, ex_rd}, 32'd8);
      check("stall_valid", {31'b0, ex_valid}, 32'd1);
    end
    flush = 1;
    step();
    check("flush_valid", {31'b0, ex_valid}, 32'd0);
    check("flush_op", {28'b0, Operation}, 32'd0);
    check("flush_rw", {31'b0, ex_reg_write}, 32'd0);
    stall = 0; flush = 0;

    // Store with forwarded rs2
    clear_id();
    id_valid = 1; id_rs1 = 2; id_rs1_data = 32'h200; id_rs2 = 7; id_rs2_data = 32'h7;
    id_imm = 32'h10; id_alu_src = 1; id_mem_write = 1;
    step();
    mem_reg_write = 1; mem_rd = 7; mem_result = 32'h1234;
    #1;
    check("st_data", ex_store_data, 32'h1234);
    check("st_srcb", SrcB, 32'h10);
    check("st_srca", SrcA, 32'h200);
    check("st_mw", {31'b0, ex_mem_write}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register for the RISC-V pipeline. Sits directly upstream of the ALU and drives its SrcA, SrcB and Operation inputs.
- Captures decoded operands and control from ID, resolves EX/MEM and MEM/WB forwarding, and selects the immediate.
- Detects load-use hazards and inserts bubbles for them.
- Handles the pipeline stall and flush controls.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- OPCODE_LENGTH, 4, ALU operation code width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- id_valid  in  1  ID slot holds a real instruction.
- id_rs1_data  in  DATA_WIDTH  register-file read data for rs1.
- id_rs2_data  in  DATA_WIDTH  register-file read data for rs2.
- id_imm  in  DATA_WIDTH  sign-extended immediate.
- id_rs1  in  REG_ADDR_W  rs1 index.
- id_rs2  in  REG_ADDR_W  rs2 index.
- id_rd  in  REG_ADDR_W  destination index.
- id_alu_op  in  OPCODE_LENGTH  ALU operation code.
- id_alu_src  in  1  1 selects imm for SrcB.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- id_mem_write  in  1  instruction is a store.
- stall  in  1  downstream stall: hold EX contents.
- flush  in  1  branch or jump redirect: kill EX contents.
- mem_rd  in  REG_ADDR_W  EX/MEM destination index.
- mem_reg_write  in  1  EX/MEM writes rd.
- mem_result  in  DATA_WIDTH  EX/MEM ALU result.
- wb_rd  in  REG_ADDR_W  MEM/WB destination index.
- wb_reg_write  in  1  MEM/WB writes rd.
- wb_result  in  DATA_WIDTH  MEM/WB write-back data.
- ex_valid  out  1  EX slot valid.
- SrcA  out  DATA_WIDTH  ALU operand A, forwarded.
- SrcB  out  DATA_WIDTH  ALU operand B, forwarded or imm.
- Operation  out  OPCODE_LENGTH  ALU operation code.
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value, for stores.
- ex_rd  out  REG_ADDR_W  EX destination index.
- ex_reg_write  out  1  EX writes rd, gated by ex_valid.
- ex_mem_read  out  1  EX is a load, gated by ex_valid.
- ex_mem_write  out  1  EX is a store, gated by ex_valid.
- load_use_hazard  out  1  combinational; IF/ID must hold.

Behaviour:
- Reset (asynchronous, active-high): all registers clear to 0.
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd and Operation are 0.
  - SrcA, SrcB and ex_store_data are 0 while forwarding inputs are inactive.
  - Reset asserted mid-operation discards the held instruction immediately, with no clock needed.
- Registered fields: valid, rs1/rs2 data, imm, rs1/rs2/rd indices, alu_op, alu_src, reg_write, mem_read, mem_write.
- load_use_hazard = ex_valid & ex_mem_read & id_valid & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - Asserted even when id_alu_src = 1, because rs2 may be a store source.
- Update at each rising edge, first matching rule wins:
  1. flush: bubble. valid and all control bits go to 0, alu_op to 0. Data fields are don't-care and are held.
  2. stall: hold every register unchanged.
  3. load_use_hazard: insert bubble, same as flush. ID is not consumed; IF/ID holds it externally.
  4. Otherwise: capture all id_* fields. valid <= id_valid.
- Forwarding is combinational from registered rs data. For operand X (rs1 or rs2):
  - If mem_reg_write & mem_rd != 0 & mem_rd == rsX: take mem_result. EX/MEM has priority.
  - Else if wb_reg_write & wb_rd != 0 & wb_rd == rsX: take wb_result.
  - Else: take the registered register-file data.
  - x0 is never forwarded.
- Output assignments:
  - SrcA = forwarded rs1.
  - ex_store_data = forwarded rs2.
  - SrcB = alu_src ? imm : forwarded rs2.
- Operation = registered alu_op. It is 0 (AND) for any bubble; the result is ignored because ex_reg_write = 0.
- Control outputs are AND-ed with ex_valid.
- Latency: ID to EX is 1 cycle. Forwarding adds no cycles.
- Simultaneous events:
  - flush with stall: flush wins.
  - flush with load_use_hazard: flush wins, and load_use_hazard still reports combinationally.
  - A stall during a hazard holds the load in EX, so the hazard persists.
- Forwarding from MEM/WB while stalled re-evaluates every cycle against the current mem/wb inputs.

Test Plan:
- Reset: assert reset async mid-cycle with the EX slot valid -> ex_valid = 0 and Operation = 0 before the next edge; all control outputs 0.
- Basic capture: id_rs1_data = 5, id_imm = 7, id_alu_src = 1, id_alu_op = 4'b0010, id_valid = 1 -> next cycle SrcA = 5, SrcB = 7, Operation = 0010, ex_valid = 1.
- Forwarding priority: EX holds rs1 = x3 with regfile value 1; mem_rd = 3, mem_result = 0xAA; wb_rd = 3, wb_result = 0xBB -> SrcA = 0xAA. Drop mem_reg_write -> SrcA = 0xBB. Set rs1 = x0 with mem_rd = 0 -> SrcA = registered value, no forwarding.
- Load-use: EX is a load with rd = x5; ID has rs2 = x5 -> load_use_hazard = 1; next edge ex_valid = 0 and ex_reg_write = 0. After the hazard clears, the held ID instruction captures normally.
- Stall vs flush: valid EX holding alu_op 0011.
  - stall = 1 for 3 cycles -> outputs unchanged.
  - stall = 1 and flush = 1 together -> next edge ex_valid = 0.
- Store data: store with rs2 = x7; mem_rd = 7, mem_result = 0x1234 -> ex_store_data = 0x1234, SrcB = imm.
